vga_timing_driver: RTL and testbench

Generates VGA 640x480@60 raster timing and drives the pixel coordinates consumed by the sprite and background renderers. It registers their combinational colour back onto the VGA DAC pins with sync and blanking aligned. It sits between the top level (50 MHz board clock, VGA connector) and every `x_pos`/`y_pos` → `R`/`G`/`B` renderer in the design. Renderers stay purely combinational; this block owns all raster state.

---
 rtl/vga_timing_driver_if.sv | 31 +++
 rtl/vga_timing_driver.sv | 109 ++++++++++
 tb/tb_vga_timing_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_driver_if.sv
// Pixel-side bundle between the VGA timing driver and the combinational renderers / DAC pins.
// The master modport is the timing driver; the slave modport is the renderer/DAC side.
interface vga_timing_driver_if;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       pix_en;
    logic       vga_clk;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;

    modport master (
        input  R, G, B,
        output x_pos, y_pos, pix_en, vga_clk, vga_r, vga_g, vga_b,
        output hsync, vsync, blank_n, sync_n, frame_start
    );

    modport slave (
        output R, G, B,
        input  x_pos, y_pos, pix_en, vga_clk, vga_r, vga_g, vga_b,
        input  hsync, vsync, blank_n, sync_n, frame_start
    );
endinterface

// File: rtl/vga_timing_driver.sv
// VGA raster timing generator: owns the pixel divider and h/v counters, and registers the
// renderers' combinational colour onto the DAC pins with sync/blank aligned one pixel later.
module vga_timing_driver #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2
) (
    input logic               clk,
    input logic               rst_n,
    vga_timing_driver_if.master vga
);
    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW   = $clog2(CLK_DIV);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
    localparam logic [9:0] HLast      = 10'(HTotal - 1);
    localparam logic [9:0] VLast      = 10'(VTotal - 1);
    localparam logic [9:0] HAct       = 10'(H_ACTIVE);
    localparam logic [9:0] VAct       = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      h_q, h_d, v_q, v_d;
    logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d;
    logic            blank_n_q, blank_n_d, frame_q, frame_d;
    logic            pix_en, active, h_wrap, v_wrap;

    always_comb begin
        pix_en    = (div_q == DivLast);
        h_wrap    = (h_q == HLast);
        v_wrap    = (v_q == VLast);
        active    = (h_q < HAct) && (v_q < VAct);
        div_d     = pix_en ? '0 : div_q + 1'b1;
        h_d       = h_q;
        v_d       = v_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        blank_n_d = blank_n_q;
        frame_d   = 1'b0;
        if (pix_en) begin
            h_d = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end
            // Pin values describe the pixel being left, so colour lags coordinates by one pixel.
            r_d       = active ? vga.R : 8'h00;
            g_d       = active ? vga.G : 8'h00;
            b_d       = active ? vga.B : 8'h00;
            blank_n_d = active;
            hsync_d   = ~((h_q >= HSyncStart) && (h_q < HSyncEnd));
            vsync_d   = ~((v_q >= VSyncStart) && (v_q < VSyncEnd));
            frame_d   = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            frame_q   <= frame_d;
        end
    end

    assign vga.x_pos       = h_q;
    assign vga.y_pos       = v_q;
    assign vga.pix_en      = pix_en;
    assign vga.vga_clk     = (div_q >= DivHalf);
    assign vga.vga_r       = r_q;
    assign vga.vga_g       = g_q;
    assign vga.vga_b       = b_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_n     = blank_n_q;
    assign vga.sync_n      = 1'b0;
    assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver on a shrunken raster so whole frames fit in a short run.
// Expected pin values are queued when each pixel is presented and popped once it reaches the pins.
module tb_vga_timing_driver;
    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int unsigned CD = 2;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT * CD;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank_n;
        logic       hsync;
        logic       vsync;
    } pins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   ff_mode = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vga_timing_driver_if vif ();

    // Combinational renderer stand-in
    assign vif.R = ff_mode ? 8'hff : vif.x_pos[7:0];
    assign vif.G = ff_mode ? 8'hff : vif.y_pos[7:0];
    assign vif.B = ff_mode ? 8'hff : (vif.x_pos[7:0] ^ 8'h5a);

    vga_timing_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV (CD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vga  (vif)
    );

    always #5 clk = ~clk;

    int    md, mh, mv, cyc, rst_cyc, last_fs;
    bit    exp_frame, have_frame, after_rst;
    int    hs_low, vs_low, blank_hi;
    pins_t exp_pins;
    pins_t sb_q[$];

    function automatic pins_t expect_pix(int h, int v);
        pins_t p;
        bit    act;
        act       = (h < HA) && (v < VA);
        p.r       = act ? (ff_mode ? 8'hff : 8'(h)) : 8'h00;
        p.g       = act ? (ff_mode ? 8'hff : 8'(v)) : 8'h00;
        p.b       = act ? (ff_mode ? 8'hff : (8'(h) ^ 8'h5a)) : 8'h00;
        p.blank_n = act;
        p.hsync   = !((h >= HA + HF) && (h < HA + HF + HS));
        p.vsync   = !((v >= VA + VF) && (v < VA + VF + VS));
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        exp_frame = 1'b0;
        if (!rst_n) begin
            md = 0; mh = 0; mv = 0;
            sb_q.delete();
            exp_pins   = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
            rst_cyc    = cyc;
            have_frame = 1'b0;
            after_rst  = 1'b1;
        end else if (md == CD - 1) begin
            sb_q.push_back(expect_pix(mh, mv));
            exp_frame = (mh == HT - 1) && (mv == VT - 1);
            md = 0;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            md++;
        end
        #1;
        if (sb_q.size() != 0) exp_pins = sb_q.pop_front();
        chk("x_pos", 32'(vif.x_pos), 32'(mh));
        chk("y_pos", 32'(vif.y_pos), 32'(mv));
        chk("pix_en", 32'(vif.pix_en), 32'(md == CD - 1));
        chk("vga_clk", 32'(vif.vga_clk), 32'(md >= CD / 2));
        chk("frame_start", 32'(vif.frame_start), 32'(exp_frame));
        chk("sync_n", 32'(vif.sync_n), 32'd0);
        chk("vga_r", 32'(vif.vga_r), 32'(exp_pins.r));
        chk("vga_g", 32'(vif.vga_g), 32'(exp_pins.g));
        chk("vga_b", 32'(vif.vga_b), 32'(exp_pins.b));
        chk("blank_n", 32'(vif.blank_n), 32'(exp_pins.blank_n));
        chk("hsync", 32'(vif.hsync), 32'(exp_pins.hsync));
        chk("vsync", 32'(vif.vsync), 32'(exp_pins.vsync));
        // Per-frame duty totals, windowed between successive frame_start pulses
        hs_low   += (vif.hsync == 1'b0) ? 1 : 0;
        vs_low   += (vif.vsync == 1'b0) ? 1 : 0;
        blank_hi += (vif.blank_n == 1'b1) ? 1 : 0;
        if (vif.frame_start === 1'b1) begin
            if (after_rst) chk("reset_to_frame", 32'(cyc - rst_cyc), 32'(FRAME));
            if (have_frame) begin
                chk("frame_period", 32'(cyc - last_fs), 32'(FRAME));
                chk("hsync_low_clks", 32'(hs_low), 32'(HS * CD * VT));
                chk("vsync_low_clks", 32'(vs_low), 32'(VS * HT * CD));
                chk("blank_hi_clks", 32'(blank_hi), 32'(HA * VA * CD));
            end
            have_frame = 1'b1;
            after_rst  = 1'b0;
            last_fs    = cyc;
            hs_low = 0; vs_low = 0; blank_hi = 0;
        end
    endtask

    initial begin
        cyc = 0; md = 0; mh = 0; mv = 0; rst_cyc = 0; last_fs = 0;
        exp_frame = 1'b0; have_frame = 1'b0; after_rst = 1'b0;
        hs_low = 0; vs_low = 0; blank_hi = 0;
        exp_pins = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (5) cycle();
        rst_n = 1'b1;
        // Two full frames plus a little with the coordinate-derived pattern
        repeat (2 * FRAME + 10) cycle();
        ff_mode = 1'b1;
        repeat (FRAME) cycle();
        ff_mode = 1'b0;
        // Walk to the middle of the visible area, then pulse reset for one clock
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (mh == 6 && mv == 3 && md == 0) break;
            cycle();
        end
        chk("reach_mid_frame", 32'((mh == 6) && (mv == 3)), 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (FRAME + 20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
